addr_result_return: RTL and testbench
=====================================

# addr_result_return

Result-return and reservation controller for the address functional units of the Cray X-MP CPU. It sits downstream of the address add unit (030/031, 2 CP) and the address multiply unit (032). The block does four things:
- tracks A-register reservations from issue to completion;
- carries each destination index through the unit latency;
- selects the finished result and drives the single A-register write port;
- holds issue on operand, destination or write-slot conflicts.

## Interface
Parameters:
- MUL_LAT, 6, address multiply latency in CP, issue edge to write edge; legal 3..8.
- ADD_LAT, 2, address add latency in CP, issue edge to write edge; fixed by the add unit.

Ports (clock and reset first):
- clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_issue  in  1  instruction issue request this CP.
- i_instr  in  7  opcode; 7'b0011000 / 7'b0011001 add/sub, 7'b0011010 multiply; others are not this block's.
- i_i  in  3  destination A index.
- i_j  in  3  first source A index.
- i_k  in  3  second source A index.
- i_add_result  in  24  add unit result.
- i_mul_result  in  24  multiply unit result.
- o_hold  out  1  issue blocked this CP (combinational).
- o_busy  out  8  A-register reservation bits; bit n set means An is pending.
- o_a_we  out  1  A-register write enable.
- o_a_waddr  out  3  A-register write index.
- o_a_wdata  out  24  A-register write data.

## Operation
- Accept condition: a request is accepted at a rising edge when i_issue=1, the opcode is 030, 031 or 032, and o_hold=0.
- Opcodes of other units are ignored. They cause no hold and no reservation.
- o_hold=1 for an own opcode with i_issue=1 when any of the following holds:
  - o_busy[i_j] is set;
  - o_busy[i_k] is set;
  - o_busy[i_i] is set (WAW);
  - the write slot this op would use is already claimed.
- o_hold is 0 whenever i_issue=0 or the opcode is foreign.
- On accept:
  - o_busy[i_i] is set.
  - The tag {valid, i_i, unit} enters the add pipe (depth ADD_LAT) or the mul pipe (depth MUL_LAT).
  - The matching bit of the write-slot vector is claimed. The vector is MUL_LAT bits and shifts one position per CP.
- Writeback: when a tag exits its pipe:
  - o_a_we=1 for exactly one CP;
  - o_a_waddr=tag index;
  - o_a_wdata=i_add_result or i_mul_result according to the tag's unit;
  - o_busy[index] is cleared at that same edge.
- Slot vector: guarantees at most one exit per edge. An add and a multiply exit on the same edge can never occur.
- Same-edge clear and issue: a busy bit that clears at edge E is still seen as set before E. A dependent issue presented in the CP ending at E holds and is accepted at E+1. There is no bypass.
- Reset (any time, including mid-operation):
  - all pipes, slot bits and o_busy are cleared;
  - pending results are dropped and never written;
  - o_a_we=0, o_a_waddr=0, o_a_wdata=0.
- Arithmetic: none. Data passes through 24 bits wide, unmodified.

## Timing
- Latency: an add accepted at edge E0 writes at edge E0+2. A multiply accepted at E0 writes at E0+MUL_LAT.
- o_a_we, o_a_waddr and o_a_wdata are registered. They are valid in the CP following the write edge.
- o_hold is a combinational function of the inputs and current state. It is sampled at the same edge as i_issue.
- Throughput: one accepted op per CP when there are no conflicts.
- Back-to-back independent adds fill every CP's write slot.
- Reset values: o_busy=8'h00, o_a_we=0, o_a_waddr=0, o_a_wdata=24'h000000, o_hold=0 with i_issue=0.

## Configuration
- ADDR_RET_MUL_EN defined:
  - multiply pipe, slot vector and 032 acceptance are compiled in.
- ADDR_RET_MUL_EN undefined:
  - 032 is treated as a foreign opcode (no hold, no reservation);
  - only the add pipe exists;
  - slot conflicts cannot occur, so the slot logic is removed.

## Test plan
- Reset then single add: issue 030 with i=3, j=1, k=2 at E0; i_add_result=24'h000123 at E2. Required: o_busy=8'h08 after E0, write A3=24'h000123 at E2, o_busy=8'h00 after E2.
- RAW hold: add to A3 at E0, then add reading j=3 requested from E1. Required: o_hold=1 in the CPs ending at E1 and E2, accept at E3.
- Write-slot conflict (MUL_LAT=6): multiply to A5 at E0, then add to A6 requested at E4 (slot E6). Required: o_hold=1 at E4, accept at E5, writes A5 at E6 and A6 at E7.
- Foreign opcode: i_instr=7'b0010000 with i_issue=1. Required: o_hold=0, o_busy unchanged, no write.
- Reset mid-operation: multiply to A1 at E0, i_rst_n low between E2 and E3. Required: o_busy=0 immediately, no write at E6.
- Macro off: 032 with i=4. Required: o_hold=0, o_busy[4] stays 0, no write ever.

Source files
------------

// File: rtl/addr_result_return.sv
// addr_result_return: reservation and result-return controller for the
// address add (030/031) and address multiply (032) units.
// It does four things:
//   - tracks A-register reservations from issue to writeback;
//   - carries each destination tag through the unit latency;
//   - drives the single A-register write port;
//   - holds issue on operand, destination or write-slot conflicts.
// Optional feature: define ADDR_RET_MUL_EN to compile in the multiply pipe,
// the write-slot vector and 032 acceptance. Without it, 032 is foreign.
module addr_result_return #(
  parameter int MUL_LAT = 6,
  parameter int ADD_LAT = 2
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_issue,
  input  logic [6:0]  i_instr,
  input  logic [2:0]  i_i,
  input  logic [2:0]  i_j,
  input  logic [2:0]  i_k,
  input  logic [23:0] i_add_result,
  input  logic [23:0] i_mul_result,
  output logic        o_hold,
  output logic [7:0]  o_busy,
  output logic        o_a_we,
  output logic [2:0]  o_a_waddr,
  output logic [23:0] o_a_wdata
);

  localparam logic [6:0] OP_ADD = 7'b0011000;
  localparam logic [6:0] OP_SUB = 7'b0011001;
  localparam logic [6:0] OP_MUL = 7'b0011010;

  // Catch an illegal multiply latency at elaboration rather than in silicon.
  if (MUL_LAT < 3 || MUL_LAT > 8) begin : g_bad_mul_lat
    $error("addr_result_return: MUL_LAT must be 3..8");
  end

  // Tag travelling with an op: unit = 1 selects the multiply result.
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic       unit;
  } tag_t;

  logic  own_add;
  logic  own_mul;
  logic  slot_conf;
  logic  hold;
  logic  accept;
  tag_t  exit_tag;
  logic [7:0] busy_next;

  tag_t add_pipe [ADD_LAT];

  assign own_add = (i_instr == OP_ADD) || (i_instr == OP_SUB);

`ifdef ADDR_RET_MUL_EN
  tag_t mul_pipe [MUL_LAT];
  // slot[d] set means a write is already booked for the edge d edges after
  // the upcoming one (slot[0] = the upcoming edge itself).
  logic [MUL_LAT-1:0] slot;
  logic [MUL_LAT-1:0] slot_next;

  assign own_mul = (i_instr == OP_MUL);
  // A multiply books the farthest slot, so only an add can collide.
  assign slot_conf = own_add && slot[ADD_LAT];
  // Slots guarantee the two pipes never exit on the same edge.
  assign exit_tag = mul_pipe[MUL_LAT-1].valid ? mul_pipe[MUL_LAT-1]
                                              : add_pipe[ADD_LAT-1];

  // Age the slot vector by one edge and book the slot of an accepted op.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    slot_next = slot >> 1;
    if (accept && own_mul)
      slot_next[MUL_LAT-1] = 1'b1;
    else if (accept)
      slot_next[ADD_LAT-1] = 1'b1;
  end

  // Multiply tag pipe and slot vector state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < MUL_LAT; s++) mul_pipe[s] <= '0;
      slot <= '0;
    end else begin
      mul_pipe[0] <= tag_t'{valid: accept && own_mul, idx: i_i, unit: 1'b1};
      for (int s = 1; s < MUL_LAT; s++) mul_pipe[s] <= mul_pipe[s-1];
      slot <= slot_next;
    end
  end
`else
  assign own_mul   = 1'b0;
  assign slot_conf = 1'b0;
  assign exit_tag  = add_pipe[ADD_LAT-1];
`endif

  // Issue interlock: no bypass, so a busy bit clearing this edge still holds.
  always_comb begin
    hold   = i_issue && (own_add || own_mul) &&
             (o_busy[i_j] || o_busy[i_k] || o_busy[i_i] || slot_conf);
    accept = i_issue && (own_add || own_mul) && !hold;
  end

  assign o_hold = hold;

  // Reservation update: release the exiting destination, reserve the new one.
  always_comb begin
    busy_next = o_busy;
    if (exit_tag.valid) busy_next[exit_tag.idx] = 1'b0;
    if (accept)         busy_next[i_i]          = 1'b1;
  end

  // Add tag pipe, reservation bits and the registered write port.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < ADD_LAT; s++) add_pipe[s] <= '0;
      o_busy    <= '0;
      o_a_we    <= 1'b0;
      o_a_waddr <= '0;
      o_a_wdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      add_pipe[0] <= tag_t'{valid: accept && own_add, idx: i_i, unit: 1'b0};
      for (int s = 1; s < ADD_LAT; s++) add_pipe[s] <= add_pipe[s-1];
      o_busy <= busy_next;
      o_a_we <= exit_tag.valid;
      if (exit_tag.valid) begin
        o_a_waddr <= exit_tag.idx;
        o_a_wdata <= exit_tag.unit ? i_mul_result : i_add_result;
      end
    end
  end

endmodule

// File: tb/tb_addr_result_return.sv
// Self-checking bench for addr_result_return. A behavioural model keeps, per
// A register, a pending flag, the edge number its result is due and the unit
// that produces it; hold, writes and reservations are derived from that.
module tb_addr_result_return;

  localparam int MUL_LAT = 6;
  localparam int ADD_LAT = 2;
`ifdef ADDR_RET_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [6:0] OP_ADD = 7'b0011000;
  localparam logic [6:0] OP_SUB = 7'b0011001;
  localparam logic [6:0] OP_MUL = 7'b0011010;
  localparam logic [6:0] OP_FGN = 7'b0010000;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_issue;
  logic [6:0]  i_instr;
  logic [2:0]  i_i, i_j, i_k;
  logic [23:0] i_add_result, i_mul_result;
  logic        o_hold;
  logic [7:0]  o_busy;
  logic        o_a_we;
  logic [2:0]  o_a_waddr;
  logic [23:0] o_a_wdata;

  addr_result_return #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_issue(i_issue), .i_instr(i_instr),
    .i_i(i_i), .i_j(i_j), .i_k(i_k),
    .i_add_result(i_add_result), .i_mul_result(i_mul_result),
    .o_hold(o_hold), .o_busy(o_busy), .o_a_we(o_a_we),
    .o_a_waddr(o_a_waddr), .o_a_wdata(o_a_wdata)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int          cyc;
  bit          pend   [8];
  int          due    [8];
  bit          unit_m [8];
  logic        exp_we;
  logic [2:0]  exp_waddr;
  logic [23:0] exp_wdata;

  int n_checks;
  int n_fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_busy();
    logic [7:0] b;
    b = '0;
    for (int r = 0; r < 8; r++) b[r] = pend[r];
    return b;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 8; r++) begin
      pend[r] = 1'b0; due[r] = 0; unit_m[r] = 1'b0;
    end
    exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
  endfunction

  // One CP: drive inputs, check hold, cross the edge, check the write port.
  task automatic step(input bit iss, input logic [6:0] op,
                      input logic [2:0] di, input logic [2:0] dj, input logic [2:0] dk,
                      input logic [23:0] ar, input logic [23:0] mr,
                      output logic hold_seen);
    bit is_add, is_mul, own, conf, hold_exp, acc;
    int lat;
    i_issue = iss; i_instr = op; i_i = di; i_j = dj; i_k = dk;
    i_add_result = ar; i_mul_result = mr;
    is_add = (op == OP_ADD) || (op == OP_SUB);
    is_mul = MUL_EN && (op == OP_MUL);
    own    = iss && (is_add || is_mul);
    lat    = is_mul ? MUL_LAT : ADD_LAT;
    conf   = 1'b0;
    for (int r = 0; r < 8; r++)
      if (pend[r] && due[r] == cyc + 1 + lat) conf = 1'b1;
    hold_exp = own && (pend[dj] || pend[dk] || pend[di] || conf);
    acc      = own && !hold_exp;
    #1;
    hold_seen = o_hold;
    check("hold", {31'b0, o_hold}, {31'b0, hold_exp});
    @(posedge clk);
    cyc++;
    exp_we = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (pend[r] && due[r] == cyc) begin
        exp_we    = 1'b1;
        exp_waddr = 3'(r);
        exp_wdata = unit_m[r] ? mr : ar;
        pend[r]   = 1'b0;
      end
    end
    if (acc) begin
      pend[di] = 1'b1; due[di] = cyc + lat; unit_m[di] = is_mul;
    end
    #1;
    check("we",    {31'b0, o_a_we},    {31'b0, exp_we});
    check("waddr", {29'b0, o_a_waddr}, {29'b0, exp_waddr});
    check("wdata", {8'b0, o_a_wdata},  {8'b0, exp_wdata});
    check("busy",  {24'b0, o_busy},    {24'b0, model_busy()});
  endtask

  task automatic idle(input int n);
    logic h;
    for (int c = 0; c < n; c++) step(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 24'h0, 24'h0, h);
  endtask

  // Asynchronous reset applied between edges, checked before the next edge.
  task automatic mid_reset();
    #2;
    i_rst_n = 1'b0;
    i_issue = 1'b0;
    #1;
    model_clear();
    check("rst_busy",  {24'b0, o_busy},    32'h0);
    check("rst_we",    {31'b0, o_a_we},    32'h0);
    check("rst_waddr", {29'b0, o_a_waddr}, 32'h0);
    check("rst_wdata", {8'b0, o_a_wdata},  32'h0);
    check("rst_hold",  {31'b0, o_hold},    32'h0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic h;
    n_checks = 0; n_fails = 0; cyc = 0;
    model_clear();
    i_rst_n = 1'b0; i_issue = 1'b0; i_instr = '0;
    i_i = '0; i_j = '0; i_k = '0; i_add_result = '0; i_mul_result = '0;
    #2;
    check("reset_busy",  {24'b0, o_busy},    32'h0);
    check("reset_we",    {31'b0, o_a_we},    32'h0);
    check("reset_waddr", {29'b0, o_a_waddr}, 32'h0);
    check("reset_wdata", {8'b0, o_a_wdata},  32'h0);
    check("reset_hold",  {31'b0, o_hold},    32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;

    // Single add: A3 <- 24'h000123, written two edges after accept.
    step(1'b1, OP_ADD, 3'd3, 3'd1, 3'd2, 24'h000123, 24'h0, h);
    check("add_busy_e0", {24'b0, o_busy}, 32'h08);
    step(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 24'h000123, 24'h0, h);
    step(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 24'h000123, 24'h0, h);
    check("add_we_e2",   {31'b0, o_a_we},    32'h1);
    check("add_addr_e2", {29'b0, o_a_waddr}, 32'h3);
    check("add_data_e2", {8'b0, o_a_wdata},  32'h000123);
    check("add_busy_e2", {24'b0, o_busy},    32'h00);
    idle(2);

    // RAW hold: the dependent add holds at E1 and E2, accepts at E3.
    step(1'b1, OP_SUB, 3'd3, 3'd0, 3'd0, 24'h00aaaa, 24'h0, h);
    step(1'b1, OP_ADD, 3'd4, 3'd3, 3'd1, 24'h00aaaa, 24'h0, h);
    check("raw_hold_e1", {31'b0, h}, 32'h1);
    step(1'b1, OP_ADD, 3'd4, 3'd3, 3'd1, 24'h00aaaa, 24'h0, h);
    check("raw_hold_e2", {31'b0, h}, 32'h1);
    step(1'b1, OP_ADD, 3'd4, 3'd3, 3'd1, 24'h00bbbb, 24'h0, h);
    check("raw_acc_e3", {31'b0, h}, 32'h0);
    idle(3);

    // Foreign opcode: no hold, no reservation, no write.
    step(1'b1, OP_FGN, 3'd2, 3'd2, 3'd2, 24'h0, 24'h0, h);
    check("fgn_hold", {31'b0, h}, 32'h0);
    check("fgn_busy", {24'b0, o_busy}, 32'h0);
    idle(3);
    check("fgn_we", {31'b0, o_a_we}, 32'h0);

`ifdef ADDR_RET_MUL_EN
    // Write-slot conflict: mul A5 at E0 owns E6; add A6 at E4 holds.
    step(1'b1, OP_MUL, 3'd5, 3'd0, 3'd1, 24'h0, 24'h0, h);
    idle(3);
    step(1'b1, OP_ADD, 3'd6, 3'd0, 3'd1, 24'h0, 24'h0, h);
    check("slot_hold_e4", {31'b0, h}, 32'h1);
    step(1'b1, OP_ADD, 3'd6, 3'd0, 3'd1, 24'h0, 24'h0, h);
    check("slot_acc_e5", {31'b0, h}, 32'h0);
    step(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 24'h111111, 24'h555555, h);
    check("slot_w5_addr", {29'b0, o_a_waddr}, 32'h5);
    check("slot_w5_data", {8'b0, o_a_wdata},  32'h555555);
    step(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 24'h666666, 24'h0, h);
    check("slot_w6_addr", {29'b0, o_a_waddr}, 32'h6);
    check("slot_w6_data", {8'b0, o_a_wdata},  32'h666666);
    idle(2);

    // Reset mid-operation: mul to A1, reset between E2 and E3, no write.
    step(1'b1, OP_MUL, 3'd1, 3'd0, 3'd2, 24'h0, 24'h0, h);
    idle(2);
    mid_reset();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 24'h0, 24'h777777, h);
      check("rst_no_write", {31'b0, o_a_we}, 32'h0);
    end
`else
    // Multiply compiled out: 032 is foreign.
    step(1'b1, OP_MUL, 3'd4, 3'd0, 3'd1, 24'h0, 24'h0, h);
    check("nomul_hold", {31'b0, h}, 32'h0);
    check("nomul_busy4", {31'b0, o_busy[4]}, 32'h0);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 24'h0, 24'h444444, h);
      check("nomul_no_write", {31'b0, o_a_we}, 32'h0);
    end

    // Reset mid-operation on an add in flight: no write afterwards.
    step(1'b1, OP_ADD, 3'd1, 3'd0, 3'd2, 24'h0, 24'h0, h);
    mid_reset();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 24'h888888, 24'h0, h);
      check("rst_no_write", {31'b0, o_a_we}, 32'h0);
    end
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [6:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)      op = OP_ADD;
      else if (sel < 5) op = OP_SUB;
      else if (sel < 8) op = OP_MUL;
      else if (sel < 9) op = OP_FGN;
      else              op = 7'b1000011;
      step($urandom_range(0, 9) < 7, op, 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           24'($urandom), 24'($urandom), h);
      if (c == 300) mid_reset();
    end
    idle(MUL_LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
